// File: rtl/qam_serial_to_parallel_if.sv
// Serial bit-stream handshake feeding the QAM serial-to-parallel converter.
// The source (master) holds bit_in and bit_valid until it sees bit_ready.
interface qam_serial_to_parallel_if;
    logic bit_in;
    logic bit_valid;
    logic bit_ready;

    modport master (
        output bit_in,
        output bit_valid,
        input  bit_ready
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        output bit_ready
    );
endinterface

// File: rtl/qam_serial_to_parallel.sv
// Gathers serial bits into SYMBOL_BITS-wide words and releases one word per symbol tick,
// flagging and counting ticks that find no staged word.
module qam_serial_to_parallel #(
    parameter int unsigned SYMBOL_BITS    = 4,
    parameter int unsigned CLK_PER_SYMBOL = 16,
    parameter bit          MSB_FIRST      = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_en,
    qam_serial_to_parallel_if.slave    s_bit,
    output logic [SYMBOL_BITS-1:0]     o_parellel_output,
    output logic                       o_sym_strobe,
    output logic                       o_underflow,
    output logic [15:0]                o_underflow_cnt
);
    localparam int unsigned CntW  = $clog2(SYMBOL_BITS + 1);
    localparam int unsigned TickW = $clog2(CLK_PER_SYMBOL);
    localparam logic [CntW-1:0]  FullCnt  = CntW'(SYMBOL_BITS);
    localparam logic [TickW-1:0] LastTick = TickW'(CLK_PER_SYMBOL - 1);

    logic [CntW-1:0]        r_shift_cnt, w_shift_cnt_d;
    logic [SYMBOL_BITS-1:0] r_asm, w_asm_d;
    logic [SYMBOL_BITS-1:0] r_stage, w_stage_d;
    logic                   r_stage_full, w_stage_full_d;
    logic [TickW-1:0]       r_tick_cnt, w_tick_cnt_d;
    logic [SYMBOL_BITS-1:0] r_par, w_par_d;
    logic                   r_strobe, w_strobe_d;
    logic                   r_uf, w_uf_d;
    logic [15:0]            r_uf_cnt, w_uf_cnt_d;

    logic                   w_tick;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_xfer;
    logic [SYMBOL_BITS:0]   w_cat;
    logic [SYMBOL_BITS-1:0] w_shifted;

    always_comb begin
        w_tick    = i_en && (r_tick_cnt == LastTick);
        w_ready   = (r_shift_cnt != FullCnt);
        w_accept  = s_bit.bit_valid && w_ready;
        // A tick empties staging this cycle, so a finished word may move in alongside it.
        w_xfer    = !w_ready && (!r_stage_full || w_tick);
        w_cat     = MSB_FIRST ? {r_asm, s_bit.bit_in} : {s_bit.bit_in, r_asm};
        w_shifted = MSB_FIRST ? w_cat[SYMBOL_BITS-1:0] : w_cat[SYMBOL_BITS:1];
    end

    assign s_bit.bit_ready = w_ready;

    always_comb begin
        w_shift_cnt_d  = r_shift_cnt;
        w_asm_d        = r_asm;
        w_stage_d      = r_stage;
        w_stage_full_d = r_stage_full;
        w_par_d        = r_par;
        w_strobe_d     = 1'b0;
        w_uf_d         = 1'b0;
        w_uf_cnt_d     = r_uf_cnt;
        w_tick_cnt_d   = (!i_en || w_tick) ? '0 : r_tick_cnt + 1'b1;

        if (w_xfer) begin
            w_shift_cnt_d = '0;
        end else if (w_accept) begin
            w_asm_d       = w_shifted;
            w_shift_cnt_d = r_shift_cnt + 1'b1;
        end

        // Availability is judged on the staging state at the start of the tick cycle.
        if (w_tick) begin
            if (r_stage_full) begin
                w_par_d        = r_stage;
                w_strobe_d     = 1'b1;
                w_stage_full_d = 1'b0;
            end else begin
                w_uf_d = 1'b1;
                if (r_uf_cnt != 16'hFFFF) begin
                    w_uf_cnt_d = r_uf_cnt + 16'd1;
                end
            end
        end

        if (w_xfer) begin
            w_stage_d      = r_asm;
            w_stage_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_cnt  <= '0;
            r_asm        <= '0;
            r_stage      <= '0;
            r_stage_full <= 1'b0;
            r_tick_cnt   <= '0;
            r_par        <= '0;
            r_strobe     <= 1'b0;
            r_uf         <= 1'b0;
            r_uf_cnt     <= '0;
        end else begin
            r_shift_cnt  <= w_shift_cnt_d;
            r_asm        <= w_asm_d;
            r_stage      <= w_stage_d;
            r_stage_full <= w_stage_full_d;
            r_tick_cnt   <= w_tick_cnt_d;
            r_par        <= w_par_d;
            r_strobe     <= w_strobe_d;
            r_uf         <= w_uf_d;
            r_uf_cnt     <= w_uf_cnt_d;
        end
    end

    assign o_parellel_output = r_par;
    assign o_sym_strobe      = r_strobe;
    assign o_underflow       = r_uf;
    assign o_underflow_cnt   = r_uf_cnt;
endmodule

// File: doc/qam_serial_to_parallel.md
Name: qam_serial_to_parallel

Overview:
- Upstream neighbour of the 16-QAM constellation mapper.
- Gathers a serial bit stream, offered on a valid/ready handshake, into SYMBOL_BITS-wide words.
- Releases one word per symbol period on a registered parallel output, which the mapper consumes directly.
- Owns the symbol-rate timebase: a clock-divider tick plus a one-cycle symbol strobe.
- Detects and counts underflow, i.e. a symbol tick arriving with no complete word available.

Parameters:
- SYMBOL_BITS, 4: bits per symbol; equals the mapper input width.
- CLK_PER_SYMBOL, 16: clock cycles per symbol period; must be at least SYMBOL_BITS + 2.
- MSB_FIRST, 1: 1 means the first received bit lands in bit [SYMBOL_BITS-1]; 0 means it lands in bit [0].

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: enables the symbol timebase.
- bit_in, input, 1: serial data bit.
- bit_valid, input, 1: bit_in is valid this cycle.
- bit_ready, output, 1: block can accept a bit this cycle. Combinational from internal state only.
- parellel_output, output, SYMBOL_BITS: current symbol word. Registered and held between ticks.
- sym_strobe, output, 1: one-cycle pulse; parellel_output took a new word this cycle.
- underflow, output, 1: one-cycle pulse; a tick found the staging register empty.
- underflow_cnt, output, 16: count of underflow events, saturating at 16'hFFFF.

Behaviour:
- Reset (asynchronous, rst_n low): every register clears.
  - parellel_output = 0, sym_strobe = 0, underflow = 0, underflow_cnt = 0.
  - Shift count = 0, staging register empty, tick counter = 0.
  - Asserting reset mid-word discards any partial word and any staged word.
- Bit accept:
  - A bit is taken on any cycle where bit_valid && bit_ready.
  - bit_ready = (shift_cnt != SYMBOL_BITS).
  - On accept, the bit shifts into the assembly register per MSB_FIRST, and shift_cnt increments.
  - bit_valid while bit_ready is low is ignored: no state change. The source must hold the bit.
- Staging:
  - Transfer happens when shift_cnt == SYMBOL_BITS and the staging register is empty, or is being emptied this cycle by a tick.
  - On transfer: the assembled word goes to staging, staging is marked full, shift_cnt returns to 0.
  - bit_ready is low on the transfer cycle. Consequence: full-rate input stalls one cycle per word.
  - If staging is full and no tick occurs, shift_cnt stays at SYMBOL_BITS and bit_ready stays low (backpressure).
- Timebase:
  - While en = 1, the tick counter counts 0 .. CLK_PER_SYMBOL-1 and wraps.
  - tick is asserted when the count == CLK_PER_SYMBOL-1.
  - en = 0 forces the counter to 0 with no tick. Bit accept and staging continue regardless of en.
  - The first tick comes CLK_PER_SYMBOL cycles after en rises.
- Tick handling:
  - Decisions use the staging state at the start of the cycle.
  - Staging full: next cycle parellel_output = staged word and sym_strobe = 1; staging becomes empty unless a same-cycle transfer refills it.
  - Staging empty: parellel_output holds its previous value, sym_strobe stays 0, underflow = 1 next cycle, and underflow_cnt increments unless already 16'hFFFF.
  - A word transferred into staging on the tick cycle itself does not count as available. That tick is an underflow, and the word goes out at the next tick.
- Latency: the last bit of a word accepted in cycle t reaches staging in cycle t+1, then appears at the first tick strictly after t+1, plus 1 cycle of registering.
- Capacity: the block holds at most 2 words, one assembled and one staged.

Test Plan:
- Reset value check: hold rst_n low mid-word after 2 of 4 bits, then release → all outputs 0, bit_ready = 1, the next 4 bits form a fresh word, and underflow_cnt = 0.
- Basic mapping (MSB_FIRST = 1): feed 1,0,1,1 before the first tick, with en rising at cycle 0 → at cycle 16, parellel_output = 4'b1011 and sym_strobe is a single-cycle pulse. Repeat with MSB_FIRST = 0 → 4'b1101.
- Continuous stream: bit_valid held high with bits from an LFSR for 64 symbols → exactly one sym_strobe every 16 cycles, output words match the LFSR sequence in order, underflow never asserted.
- Backpressure: supply 12 bits with no ticks (en = 0) → after 8 bits bit_ready stays low and the 9th bit is held. Set en = 1 → the first tick outputs word 1, bit_ready reasserts, the remaining bits flow in, and ticks 2 and 3 output words 2 and 3 with no data lost.
- Underflow: en = 1 with no input for 3 symbol periods → 3 underflow pulses at cycles 16, 32 and 48, underflow_cnt = 3, parellel_output held at 0. Completing a word exactly on a tick cycle → underflow pulse on that tick, word output at the following tick.
- Saturation: force 65,540 underflow ticks → underflow_cnt stops at 16'hFFFF while underflow keeps pulsing.
